// File: rtl/alu_ctrl_pkg.sv
// Shared op codes, sequencer states and widths for the ALU request sequencer.
package alu_ctrl_pkg;

    localparam int OP_W      = 3;
    localparam int OPERAND_W = 4;
    localparam int RESULT_W  = 8;

    typedef enum logic [OP_W-1:0] {
        OP_CMPA = 3'd0,
        OP_CMPB = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_MUL  = 3'd6,
        OP_MULH = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        EXEC_HI,
        RESP
    } seq_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_req_sequencer_if.sv
// Requester and response side of the ALU sequencer: per-requester valid/ready plus one response channel.
interface alu_req_sequencer_if import alu_ctrl_pkg::*; #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = id_width(NUM_REQ)
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [OP_W*NUM_REQ-1:0]      req_op;
    logic [OPERAND_W*NUM_REQ-1:0] req_a;
    logic [OPERAND_W*NUM_REQ-1:0] req_b;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [ID_W-1:0]              rsp_id;
    logic [RESULT_W-1:0]          rsp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/alu_req_sequencer_arbiter.sv
// One-hot arbiter: round-robin from the index after the last grant, or fixed lowest-index priority.
module rr_arbiter import alu_ctrl_pkg::*; #(
    parameter int NUM_REQ    = 2,
    parameter int FIXED_PRIO = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);
    localparam int IDX_W = id_width(NUM_REQ);

    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] grant_idx;

    // Fixed priority is round-robin with the pointer pinned to the top index.
    assign base = (FIXED_PRIO != 0) ? IDX_W'(NUM_REQ - 1) : last;

    // Scan from lowest to highest priority so the last hit wins.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        grant     = '0;
        grant_idx = base;
        cand      = 0;
        cand_idx  = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand     = (int'(base) + off) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                grant           = '0;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= IDX_W'(NUM_REQ - 1);
        end else if (advance && (|req)) begin
            last <= grant_idx;
        end
    end

endmodule

// File: rtl/alu_req_sequencer.sv
// Shares one external 4-bit ALU between NUM_REQ requesters; MUL takes two passes for an 8-bit product.
module alu_req_sequencer import alu_ctrl_pkg::*; #(
    parameter int NUM_REQ    = 2,
    parameter int FIXED_PRIO = 0,
    parameter int ID_W       = id_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_req_sequencer_if.slave   bus,
    output logic [OPERAND_W-1:0] alu_a,
    output logic [OPERAND_W-1:0] alu_b,
    output logic [OP_W-1:0]      alu_s,
    input  logic [OPERAND_W-1:0] alu_out,
    output logic                 busy
);
    seq_state_e           state;
    seq_state_e           state_next;
    logic [NUM_REQ-1:0]   grant;
    logic                 accept;
    logic [OP_W-1:0]      sel_op;
    logic [OPERAND_W-1:0] sel_a;
    logic [OPERAND_W-1:0] sel_b;
    logic [ID_W-1:0]      sel_id;
    logic [RESULT_W-1:0]  data_q;
    logic [ID_W-1:0]      id_q;

    assign accept = (state == IDLE) && (|bus.req_valid);

    rr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req_valid),
        .advance (accept),
        .grant   (grant)
    );

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        sel_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op = bus.req_op[OP_W*i +: OP_W];
                sel_a  = bus.req_a[OPERAND_W*i +: OPERAND_W];
                sel_b  = bus.req_b[OPERAND_W*i +: OPERAND_W];
                sel_id = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A MUL is recognised in EXEC because alu_s still holds the low-half select there.
    always_comb begin
        state_next    = state;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                bus.req_ready = grant;
                if (accept) state_next = EXEC;
            end
            EXEC:    state_next = (alu_s == OP_MUL) ? EXEC_HI : RESP;
            EXEC_HI: state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_s  <= '0;
            data_q <= '0;
            id_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a <= sel_a;
                        alu_b <= sel_b;
                        alu_s <= sel_op;
                        id_q  <= sel_id;
                    end
                end
                EXEC: begin
                    data_q <= {4'h0, alu_out};
                    if (alu_s == OP_MUL) alu_s <= OP_MULH;
                end
                EXEC_HI: data_q[7:4] <= alu_out;
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_id    = id_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Self-checking bench: a round-robin and a fixed-priority sequencer, each behind its own behavioural ALU.
module tb_alu_req_sequencer;
    import alu_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] alu_a0, alu_b0, alu_out0, alu_a1, alu_b1, alu_out1;
    logic [2:0] alu_s0, alu_s1;
    logic       busy0, busy1;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         model_last0 = 1;
    int         model_last1 = 1;

    alu_req_sequencer_if #(.NUM_REQ(2), .ID_W(1)) bus0 ();
    alu_req_sequencer_if #(.NUM_REQ(2), .ID_W(1)) bus1 ();

    alu_req_sequencer #(.NUM_REQ(2), .FIXED_PRIO(0), .ID_W(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_s(alu_s0), .alu_out(alu_out0), .busy(busy0)
    );

    alu_req_sequencer #(.NUM_REQ(2), .FIXED_PRIO(1), .ID_W(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_s(alu_s1), .alu_out(alu_out1), .busy(busy1)
    );

    // Stand-in for the existing combinational ALU.
    function automatic logic [3:0] alu_fn(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = {4'h0, a} * {4'h0, b};
        case (s)
            3'd0:    return ~a + 4'd1;
            3'd1:    return ~b + 4'd1;
            3'd2:    return a + b;
            3'd3:    return (a >= b) ? a - b : b - a;
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return p[3:0];
            default: return p[7:4];
        endcase
    endfunction

    assign alu_out0 = alu_fn(alu_s0, alu_a0, alu_b0);
    assign alu_out1 = alu_fn(alu_s1, alu_a1, alu_b1);

    // Reference result straight from the op definitions.
    function automatic logic [7:0] exp_result(input int op, input int a, input int b);
        int r;
        case (op)
            0:       r = (16 - a) % 16;
            1:       r = (16 - b) % 16;
            2:       r = (a + b) % 16;
            3:       r = (a > b) ? a - b : b - a;
            4:       r = a & b;
            5:       r = a | b;
            6:       r = a * b;
            default: r = (a * b) / 16;
        endcase
        return 8'(r);
    endfunction

    // Service order: the index after the last grant first, or index order when fixed.
    function automatic int model_pick(input logic [1:0] valid, input int last, input bit fixed);
        int order [2];
        if (fixed) begin
            order[0] = 0;
            order[1] = 1;
        end else begin
            order[0] = (last + 1) % 2;
            order[1] = last;
        end
        foreach (order[k]) if (valid[order[k]]) return order[k];
        return -1;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_rsp(input int dut, output bit got, output int lat, output logic [7:0] d,
                            output logic [0:0] id, output logic [2:0] s1, output logic [2:0] s2);
        lat = 0;
        s1  = '0;
        s2  = '0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) s1 = (dut == 0) ? alu_s0 : alu_s1;
            if (lat == 2) s2 = (dut == 0) ? alu_s0 : alu_s1;
        end while (!((dut == 0) ? bus0.rsp_valid : bus1.rsp_valid) && lat < 12);
        got = (dut == 0) ? bus0.rsp_valid : bus1.rsp_valid;
        d   = (dut == 0) ? bus0.rsp_data : bus1.rsp_data;
        id  = (dut == 0) ? bus0.rsp_id : bus1.rsp_id;
    endtask

    task automatic txn(input int r, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       output bit acc, output bit got, output int lat, output logic [7:0] d,
                       output logic [0:0] id, output logic [2:0] s1, output logic [2:0] s2);
        int waited;
        @(negedge clk);
        bus0.req_op[3*r +: 3] = op;
        bus0.req_a[4*r +: 4]  = a;
        bus0.req_b[4*r +: 4]  = b;
        bus0.req_valid[r]     = 1'b1;
        #1;
        waited = 0;
        while (!bus0.req_ready[r] && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        acc = bus0.req_ready[r];
        @(posedge clk);
        #1;
        bus0.req_valid[r] = 1'b0;
        if (acc) model_last0 = r;
        wait_rsp(0, got, lat, d, id, s1, s2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus0.req_valid = '0; bus0.req_op = '0; bus0.req_a = '0; bus0.req_b = '0; bus0.rsp_ready = 1'b1;
        bus1.req_valid = '0; bus1.req_op = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (bus0.rsp_valid !== 1'b0 || bus1.rsp_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b/%b, required 0/0", bus0.rsp_valid, bus1.rsp_valid);
        end
        n_checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_busy: got %b/%b, required 0/0", busy0, busy1);
        end
        n_checks++;
        if (bus0.rsp_data !== 8'h00 || bus0.rsp_id !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_rsp: data %h id %h, required 00 0", bus0.rsp_data, bus0.rsp_id);
        end
        n_checks++;
        if (alu_a0 !== 4'h0 || alu_b0 !== 4'h0 || alu_s0 !== 3'h0) begin
            n_fail++; $display("[TB] FAIL reset_alu: a %h b %h s %h, required 0 0 0", alu_a0, alu_b0, alu_s0);
        end
        n_checks++;
        if (bus0.req_ready !== 2'b00) begin
            n_fail++; $display("[TB] FAIL reset_req_ready: got %b, required 00", bus0.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_last0 = 1;
        model_last1 = 1;
    endtask

    task automatic test_add();
        bit acc, got; int lat; logic [7:0] d; logic [0:0] id; logic [2:0] s1, s2;
        txn(0, OP_ADD, 4'd3, 4'd4, acc, got, lat, d, id, s1, s2);
        n_checks++;
        if (!acc || !got || lat != 2) begin
            n_fail++; $display("[TB] FAIL add_latency: acc %b got %b latency %0d, required 1 1 2", acc, got, lat);
        end
        n_checks++;
        if (d !== 8'h07 || id !== 1'b0) begin
            n_fail++; $display("[TB] FAIL add_result: data %h id %h, required 07 0", d, id);
        end
    endtask

    task automatic test_mul();
        bit acc, got; int lat; logic [7:0] d; logic [0:0] id; logic [2:0] s1, s2;
        txn(1, OP_MUL, 4'd13, 4'd11, acc, got, lat, d, id, s1, s2);
        n_checks++;
        if (s1 !== 3'd6 || s2 !== 3'd7) begin
            n_fail++; $display("[TB] FAIL mul_select_seq: got %0d,%0d required 6,7", s1, s2);
        end
        n_checks++;
        if (!got || lat != 3) begin
            n_fail++; $display("[TB] FAIL mul_latency: got %b latency %0d, required 1 3", got, lat);
        end
        n_checks++;
        if (d !== 8'h8F || id !== 1'b1) begin
            n_fail++; $display("[TB] FAIL mul_result: data %h id %h, required 8f 1", d, id);
        end
    endtask

    task automatic test_ops();
        bit acc, got; int lat; logic [7:0] d; logic [0:0] id; logic [2:0] s1, s2;
        int op_t [4] = '{3, 0, 7, 1};
        int a_t  [4] = '{2, 1, 15, 9};
        int b_t  [4] = '{5, 0, 15, 0};
        b_t[1] = int'($urandom_range(0, 15));
        for (int k = 0; k < 4; k++) begin
            txn(k % 2, 3'(op_t[k]), 4'(a_t[k]), 4'(b_t[k]), acc, got, lat, d, id, s1, s2);
            n_checks++;
            if (!got || lat != 2 || d !== exp_result(op_t[k], a_t[k], b_t[k]) || id !== 1'(k % 2)) begin
                n_fail++;
                $display("[TB] FAIL op%0d_result: got %b latency %0d data %h id %h, required 1 2 %h %0d",
                         op_t[k], got, lat, d, id, exp_result(op_t[k], a_t[k], b_t[k]), k % 2);
            end
        end
    endtask

    task automatic test_simultaneous();
        bit got; int lat, exp_id; logic [7:0] d; logic [0:0] id; logic [2:0] s1, s2;
        int op_t [2] = '{2, 5};
        int a_t  [2] = '{1, 5};
        int b_t  [2] = '{1, 10};
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_last0 = 1;
        bus0.req_op = {3'(op_t[1]), 3'(op_t[0])};
        bus0.req_a  = {4'(a_t[1]), 4'(a_t[0])};
        bus0.req_b  = {4'(b_t[1]), 4'(b_t[0])};
        bus0.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(0, got, lat, d, id, s1, s2);
            exp_id = model_pick(2'b11, model_last0, 1'b0);
            n_checks++;
            if (!got || id !== 1'(exp_id) || d !== exp_result(op_t[exp_id], a_t[exp_id], b_t[exp_id])) begin
                n_fail++;
                $display("[TB] FAIL rr_order%0d: got %b id %h data %h, required 1 %0d %h", k, got, id, d,
                         exp_id, exp_result(op_t[exp_id], a_t[exp_id], b_t[exp_id]));
            end
            model_last0 = exp_id;
        end
        bus0.req_valid = 2'b00;
    endtask

    task automatic test_fixed_prio();
        bit got; int lat, exp_id; logic [7:0] d; logic [0:0] id; logic [2:0] s1, s2;
        @(negedge clk);
        bus1.req_op = {3'(OP_OR), 3'(OP_ADD)};
        bus1.req_a  = {4'h5, 4'h1};
        bus1.req_b  = {4'hA, 4'h1};
        bus1.req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wait_rsp(1, got, lat, d, id, s1, s2);
            exp_id = model_pick(2'b11, model_last1, 1'b1);
            n_checks++;
            if (!got || id !== 1'(exp_id) || d !== 8'h02) begin
                n_fail++; $display("[TB] FAIL fixed_prio%0d: got %b id %h data %h, required 1 %0d 02", k, got, id, d, exp_id);
            end
            model_last1 = exp_id;
        end
        bus1.req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        bit acc, got; int lat; logic [7:0] d; logic [0:0] id; logic [2:0] s1, s2;
        bus0.rsp_ready = 1'b0;
        txn(0, OP_AND, 4'hC, 4'hA, acc, got, lat, d, id, s1, s2);
        n_checks++;
        if (!got || d !== 8'h08 || id !== 1'b0) begin
            n_fail++; $display("[TB] FAIL bp_first: got %b data %h id %h, required 1 08 0", got, d, id);
        end
        bus0.req_op[5:3]  = OP_ADD;
        bus0.req_a[7:4]   = 4'd7;
        bus0.req_b[7:4]   = 4'd5;
        bus0.req_valid[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (bus0.rsp_valid !== 1'b1 || bus0.rsp_data !== 8'h08 || bus0.rsp_id !== 1'b0 || bus0.req_ready !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL bp_hold%0d: valid %b data %h id %h ready %b, required 1 08 0 00",
                         k, bus0.rsp_valid, bus0.rsp_data, bus0.rsp_id, bus0.req_ready);
            end
            @(negedge clk);
        end
        bus0.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus0.req_ready !== 2'b10) begin
            n_fail++; $display("[TB] FAIL bp_next_grant: got %b, required 10", bus0.req_ready);
        end
        @(posedge clk);
        #1;
        bus0.req_valid[1] = 1'b0;
        model_last0 = 1;
        wait_rsp(0, got, lat, d, id, s1, s2);
        n_checks++;
        if (!got || lat != 2 || d !== 8'h0C || id !== 1'b1) begin
            n_fail++; $display("[TB] FAIL bp_waiting_req: got %b latency %0d data %h id %h, required 1 2 0c 1", got, lat, d, id);
        end
    endtask

    task automatic test_random();
        logic [2:0] p_op [2];
        logic [3:0] p_a  [2];
        logic [3:0] p_b  [2];
        int         q_id [$];
        logic [7:0] q_data [$];
        logic [1:0] exp_rdy;
        int         pick, drop;
        bus0.rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc >= 300 && q_id.size() == 0 && bus0.req_valid == 2'b00) break;
            @(negedge clk);
            if (cyc < 300) begin
                for (int r = 0; r < 2; r++) begin
                    if (!bus0.req_valid[r] && $urandom_range(0, 2) == 0) begin
                        p_op[r] = 3'($urandom_range(0, 7));
                        p_a[r]  = 4'($urandom_range(0, 15));
                        p_b[r]  = 4'($urandom_range(0, 15));
                        bus0.req_op[3*r +: 3] = p_op[r];
                        bus0.req_a[4*r +: 4]  = p_a[r];
                        bus0.req_b[4*r +: 4]  = p_b[r];
                        bus0.req_valid[r]     = 1'b1;
                    end
                end
            end
            bus0.rsp_ready = ($urandom_range(0, 3) != 0) || (cyc >= 300);
            #1;
            if (bus0.rsp_valid && bus0.rsp_ready) begin
                n_checks++;
                if (q_id.size() == 0) begin
                    n_fail++; $display("[TB] FAIL rand_unexpected_rsp: id %h data %h, required no response", bus0.rsp_id, bus0.rsp_data);
                end else begin
                    if (bus0.rsp_id !== 1'(q_id[0]) || bus0.rsp_data !== q_data[0]) begin
                        n_fail++;
                        $display("[TB] FAIL rand_rsp: id %h data %h, required %0d %h", bus0.rsp_id, bus0.rsp_data, q_id[0], q_data[0]);
                    end
                    void'(q_id.pop_front());
                    void'(q_data.pop_front());
                end
            end
            drop = -1;
            exp_rdy = 2'b00;
            if (!busy0 && (|bus0.req_valid)) begin
                pick = model_pick(bus0.req_valid, model_last0, 1'b0);
                exp_rdy = 2'(1 << pick);
                q_id.push_back(pick);
                q_data.push_back(exp_result(p_op[pick], p_a[pick], p_b[pick]));
                model_last0 = pick;
                drop = pick;
            end
            n_checks++;
            if (bus0.req_ready !== exp_rdy) begin
                n_fail++; $display("[TB] FAIL rand_grant cyc%0d: got %b, required %b", cyc, bus0.req_ready, exp_rdy);
            end
            @(posedge clk);
            #1;
            if (drop >= 0) bus0.req_valid[drop] = 1'b0;
        end
        n_checks++;
        if (q_id.size() != 0 || bus0.req_valid != 2'b00) begin
            n_fail++; $display("[TB] FAIL rand_drain: %0d responses outstanding, valid %b, required 0 00", q_id.size(), bus0.req_valid);
        end
    endtask

    task automatic test_reset_exec_hi();
        bit acc, got, seen; int lat; logic [7:0] d; logic [0:0] id; logic [2:0] s1, s2;
        @(negedge clk);
        bus0.req_op[2:0]  = OP_MUL;
        bus0.req_a[3:0]   = 4'd9;
        bus0.req_b[3:0]   = 4'd7;
        bus0.req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        bus0.req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (alu_s0 !== 3'd7 || busy0 !== 1'b1) begin
            n_fail++; $display("[TB] FAIL rst_pre_exec_hi: alu_s %0d busy %b, required 7 1", alu_s0, busy0);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus0.rsp_valid !== 1'b0 || busy0 !== 1'b0 || alu_a0 !== 4'h0 || alu_b0 !== 4'h0 || alu_s0 !== 3'h0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_mul: valid %b busy %b a %h b %h s %h, required 0 0 0 0 0",
                     bus0.rsp_valid, busy0, alu_a0, alu_b0, alu_s0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_last0 = 1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= bus0.rsp_valid;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rst_dropped: response seen %b, required 0", seen);
        end
        txn(1, OP_ADD, 4'd6, 4'd3, acc, got, lat, d, id, s1, s2);
        n_checks++;
        if (!got || lat != 2 || d !== 8'h09 || id !== 1'b1) begin
            n_fail++; $display("[TB] FAIL rst_recover: got %b latency %0d data %h id %h, required 1 2 09 1", got, lat, d, id);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_ops();
        test_simultaneous();
        test_fixed_prio();
        test_backpressure();
        test_random();
        test_reset_exec_hi();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
